ads8556_emu: RTL

- Synthesizable model of the ADS8556 six-channel parallel ADC: the device side of the interface that ads8556_wrraper drives.
- Responds to conv, wrn, rdn and csn: asserts busy, returns channel words on reads, and latches the 32-bit config word on writes.
- Used in hardware-in-loop builds and benches to feed the tcd1304 DAQ chain with deterministic pixel data, without a real ADC.

---
 rtl/ads8556_emu_pkg.sv | 41 ++++
 rtl/ads8556_emu_edge_sync.sv | 37 +++
 rtl/ads8556_emu.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ads8556_emu_pkg.sv
// Shared constants, state encoding and channel pattern generator for the ADS8556 emulator.
package ads8556_emu_pkg;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = 3;
  localparam int unsigned CFG_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    READY = 2'd2
  } emu_state_e;

  localparam logic [1:0] PAT_RAMP = 2'd0;
  localparam logic [1:0] PAT_TAG  = 2'd1;
  localparam logic [1:0] PAT_EXT  = 2'd2;

  localparam logic [DATA_W-1:0] TAG_BASE = 16'hA5A0;
  localparam logic [DATA_W-1:0] CH_STEP  = 16'h1000;

  // Value of channel k for sample n under the selected pattern; mode 3 aliases the ramp.
  function automatic logic [DATA_W-1:0] chan_value(
    input logic [1:0]               mode,
    input logic [DATA_W-1:0]        n,
    input logic [PTR_W-1:0]         k,
    input logic [NUM_CH*DATA_W-1:0] ext
  );
    logic [DATA_W-1:0] ramp;
    logic [DATA_W-1:0] v;
    ramp = n + DATA_W'(k) * CH_STEP;
    case (mode)
      PAT_RAMP: v = ramp;
      PAT_TAG:  v = TAG_BASE | DATA_W'(k);
      PAT_EXT:  v = ext[k*DATA_W +: DATA_W];
      default:  v = ramp;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ads8556_emu_edge_sync.sv
// Multi-flop synchronizer for one control pin with rise/fall pulses on the synchronized copy.
module emu_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Reset to the pin's idle level so release of rst never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_c = q_o & ~prev_q;
  assign fall_c = ~q_o & prev_q;

endmodule

// File: rtl/ads8556_emu.sv
// Device-side ADS8556 model: conversion timing, shadowed channel reads and config writes.
module ads8556_emu
  import ads8556_emu_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 140,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ads_conv,
  input  logic                     ads_csn,
  input  logic                     ads_rdn,
  input  logic                     ads_wrn,
  input  logic                     ads_standbyn,
  input  logic                     ads_reset,
  output logic                     ads_busy,
  input  logic [DATA_W-1:0]        ads_data_i,
  output logic [DATA_W-1:0]        ads_data_o,
  output logic                     ads_data_oe,
  input  logic [1:0]               pat_mode,
  input  logic [NUM_CH*DATA_W-1:0] ext_data,
  output logic [CFG_W-1:0]         cfg_word,
  output logic                     cfg_valid,
  output logic [DATA_W-1:0]        sample_cnt,
  output logic                     conv_overrun,
  output logic                     bus_err
);

  localparam int unsigned       NUM_CTRL  = 6;
  // Idle levels in {reset, standbyn, wrn, rdn, csn, conv} order.
  localparam logic [NUM_CTRL-1:0] CTRL_IDLE = 6'b011110;
  localparam logic [DATA_W-1:0] CNT_LOAD  = DATA_W'(CONV_CYCLES - 1);

  logic [NUM_CTRL-1:0] ctrl_raw, ctrl_s, ctrl_rise, ctrl_fall;
  assign ctrl_raw = {ads_reset, ads_standbyn, ads_wrn, ads_rdn, ads_csn, ads_conv};

  for (genvar i = 0; i < NUM_CTRL; i++) begin : g_sync
    emu_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (CTRL_IDLE[i])
    ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (ctrl_raw[i]),
      .q_o    (ctrl_s[i]),
      .rise_c (ctrl_rise[i]),
      .fall_c (ctrl_fall[i])
    );
  end

  logic conv_rise, csn_s, rdn_s, rdn_fall, wrn_s, wrn_rise, standbyn_s, reset_s;
  logic strobe_clash, rd_ev, wr_ev;
  logic unused_ctrl;

  assign conv_rise  = ctrl_rise[0];
  assign csn_s      = ctrl_s[1];
  assign rdn_s      = ctrl_s[2];
  assign rdn_fall   = ctrl_fall[2];
  assign wrn_s      = ctrl_s[3];
  assign wrn_rise   = ctrl_rise[3];
  assign standbyn_s = ctrl_s[4];
  assign reset_s    = ctrl_s[5];
  assign unused_ctrl = ^{ctrl_s[0], ctrl_rise[5:4], ctrl_rise[2:1], ctrl_fall[5:3], ctrl_fall[1:0]};

  // A strobe edge only counts while the opposite strobe is idle.
  assign strobe_clash = ~csn_s & ~rdn_s & ~wrn_s;
  assign rd_ev        = rdn_fall & ~csn_s & wrn_s;
  assign wr_ev        = wrn_rise & ~csn_s & rdn_s;

  emu_state_e        state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [PTR_W-1:0]  ch_ptr_q, ch_ptr_d;
  logic              word_ptr_q, word_ptr_d;
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [DATA_W-1:0] shadow_d [NUM_CH];
  logic [DATA_W-1:0] cfg_hi_q, cfg_hi_d;
  logic [CFG_W-1:0]  cfg_word_q, cfg_word_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic [DATA_W-1:0] sample_cnt_q, sample_cnt_d;
  logic              conv_overrun_q, conv_overrun_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] data_o_q, data_o_d;
  logic              oe_q, oe_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    ch_ptr_d       = ch_ptr_q;
    word_ptr_d     = word_ptr_q;
    shadow_d       = shadow_q;
    cfg_hi_d       = cfg_hi_q;
    cfg_word_d     = cfg_word_q;
    cfg_valid_d    = 1'b0;
    sample_cnt_d   = sample_cnt_q;
    conv_overrun_d = conv_overrun_q;
    bus_err_d      = bus_err_q | strobe_clash;
    data_o_d       = data_o_q;
    oe_d           = 1'b0;

    if (reset_s) begin
      state_d    = IDLE;
      cnt_d      = '0;
      busy_d     = 1'b0;
      ch_ptr_d   = '0;
      word_ptr_d = 1'b0;
      shadow_d   = '{default: '0};
      cfg_hi_d   = '0;
      cfg_word_d = '0;
      data_o_d   = '0;
    end else if (!standbyn_s) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      ch_ptr_d = '0;
    end else begin
      oe_d = ~csn_s & ~rdn_s & wrn_s;

      if (rd_ev) begin
        data_o_d = shadow_q[ch_ptr_q];
        if (state_q != CONV) begin
          ch_ptr_d = (ch_ptr_q == PTR_W'(NUM_CH - 1)) ? '0 : ch_ptr_q + 1'b1;
        end
      end

      if (wr_ev) begin
        word_ptr_d = ~word_ptr_q;
        if (!word_ptr_q) begin
          cfg_hi_d = ads_data_i;
        end else begin
          cfg_word_d  = {cfg_hi_q, ads_data_i};
          cfg_valid_d = 1'b1;
        end
      end

      // Conversion start placed after the read so a coincident read still sees the old shadow.
      if (state_q == CONV) begin
        if (conv_rise) conv_overrun_d = 1'b1;
        if (cnt_q == '0) begin
          state_d      = READY;
          busy_d       = 1'b0;
          ch_ptr_d     = '0;
          sample_cnt_d = sample_cnt_q + 16'd1;
          for (int k = 0; k < NUM_CH; k++) begin
            shadow_d[k] = chan_value(pat_mode, sample_cnt_q, PTR_W'(k), ext_data);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end else if (conv_rise) begin
        state_d  = CONV;
        busy_d   = 1'b1;
        cnt_d    = CNT_LOAD;
        ch_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      ch_ptr_q       <= '0;
      word_ptr_q     <= 1'b0;
      shadow_q       <= '{default: '0};
      cfg_hi_q       <= '0;
      cfg_word_q     <= '0;
      cfg_valid_q    <= 1'b0;
      sample_cnt_q   <= '0;
      conv_overrun_q <= 1'b0;
      bus_err_q      <= 1'b0;
      data_o_q       <= '0;
      oe_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      ch_ptr_q       <= ch_ptr_d;
      word_ptr_q     <= word_ptr_d;
      shadow_q       <= shadow_d;
      cfg_hi_q       <= cfg_hi_d;
      cfg_word_q     <= cfg_word_d;
      cfg_valid_q    <= cfg_valid_d;
      sample_cnt_q   <= sample_cnt_d;
      conv_overrun_q <= conv_overrun_d;
      bus_err_q      <= bus_err_d;
      data_o_q       <= data_o_d;
      oe_q           <= oe_d;
    end
  end

  assign ads_busy     = busy_q;
  assign ads_data_o   = data_o_q;
  assign ads_data_oe  = oe_q;
  assign cfg_word     = cfg_word_q;
  assign cfg_valid    = cfg_valid_q;
  assign sample_cnt   = sample_cnt_q;
  assign conv_overrun = conv_overrun_q;
  assign bus_err      = bus_err_q;

endmodule
